m_dmem_ctrl: RTL and testbench

Memory-stage data-memory controller for the pipelined MIPS core. It takes a load/store request from the M stage and generates word-aligned byte-enabled transactions on a req/ack data bus. It stalls the pipeline until the bus acknowledges, then hands the raw 32-bit bus word to the M-stage data-extension stage, which does the lb/lh/lw selection and sign extension. The block is directly upstream of data extension: it never shifts or extends read data itself.

---
 rtl/m_dmem_ctrl_pkg.sv | 22 ++
 rtl/m_dmem_ctrl_be_gen.sv | 37 +++
 rtl/m_dmem_ctrl.sv | 132 +++++++++++++
 tb/tb_m_dmem_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_dmem_ctrl_pkg.sv
// m_dmem_ctrl_pkg: shared definitions for the M-stage data-memory controller.
// Holds the access-size codes, the controller FSM encoding and an address helper.
// Imported by m_be_gen and m_dmem_ctrl.
package m_dmem_ctrl_pkg;

  // Access size codes as they arrive from the M stage (2'b11 behaves as a word).
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // The bus is word addressed; sub-word selection is carried by the byte enables.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/m_dmem_ctrl_be_gen.sv
// m_be_gen: maps (size, addr[1:0], wdata) to byte enables, lane-replicated write data
//   and a misalignment flag. Purely combinational, zero latency, no backpressure.
// Ports: size/addr_lo/wdata in; be/lane_wdata/misaligned out.
module m_be_gen
  import m_dmem_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic        misaligned
);

  always_comb begin
    be         = 4'b1111;
    lane_wdata = wdata;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        be         = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
      end
      SZ_H: begin
        // Half selection only looks at addr[1]; addr[0] is reported, not used.
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      default: begin
        // Word and the reserved 2'b11 code: full word, any low address bit is misaligned.
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/m_dmem_ctrl.sv
// m_dmem_ctrl: M-stage load/store to req/ack bus controller (IDLE -> BUSY -> DONE).
// Latency: 3 cycles minimum (IDLE, BUSY with ack, DONE), +1 per bus wait cycle.
// Backpressure: stall holds the pipeline until DONE; a bus timeout ends BUSY with err.
// Ports: clk/reset (async active-low); req_* from M stage; stall/rdata/rdata_valid/err/
//   exc_adel/exc_ades to pipeline; bus_* to/from data bus.
// Build option: MISALIGN_EXC_EN raises address exceptions for misaligned half/word
//   accesses instead of silently forcing alignment.
module m_dmem_ctrl
  import m_dmem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] count;
  logic [3:0]  be;
  logic [31:0] lane_wdata;
  logic        misaligned;
  logic        aligned;
  logic        start;
  logic        ack_hit;
  logic        timeout_hit;

  m_be_gen u_be_gen (
    .size       (req_size),
    .addr_lo    (req_addr[1:0]),
    .wdata      (req_wdata),
    .be         (be),
    .lane_wdata (lane_wdata),
    .misaligned (misaligned)
  );

`ifdef MISALIGN_EXC_EN
  // A misaligned access never leaves IDLE; the exception is flagged while it sits in M.
  assign aligned  = ~misaligned;
  assign exc_adel = (state == ST_IDLE) && req_valid && misaligned && !req_we;
  assign exc_ades = (state == ST_IDLE) && req_valid && misaligned && req_we;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign aligned  = 1'b1;
  assign exc_adel = 1'b0;
  assign exc_ades = 1'b0;
`endif

  // Ack takes priority over a timeout landing in the same cycle.
  assign start       = (state == ST_IDLE) && req_valid && aligned;
  assign ack_hit     = (state == ST_BUSY) && bus_ack;
  assign timeout_hit = (state == ST_BUSY) && !bus_ack &&
                       (TIMEOUT_CYC != 0) && (count == TIMEOUT_CYC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = req_valid && aligned && (state != ST_DONE);
    case (state)
      ST_IDLE: if (start) state_nxt = ST_BUSY;
      ST_BUSY: if (ack_hit || timeout_hit) state_nxt = ST_DONE;
      // The same instruction is still in M during DONE, so it is not re-examined.
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs are registered so they are high exactly while the FSM is in BUSY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
      count     <= 32'h0;
    end else if (start) begin
      bus_req   <= 1'b1;
      bus_we    <= req_we;
      bus_addr  <= word_align(req_addr);
      bus_be    <= be;
      bus_wdata <= lane_wdata;
      count     <= 32'h0;
    end else if (ack_hit || timeout_hit) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
    end else if (state == ST_BUSY) begin
      count <= count + 32'd1;
    end
  end

  // Completion side: rdata holds between captures; pulses line up with DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata       <= 32'h0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (ack_hit)          rdata <= bus_rdata;
      else if (timeout_hit) rdata <= 32'h0;
      rdata_valid <= ack_hit && !bus_we;
      err         <= timeout_hit;
    end
  end

endmodule

// File: tb/tb_m_dmem_ctrl.sv
module tb_m_dmem_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        bus_ack, t_bus_ack;
  logic [31:0] bus_rdata;

  logic        stall, rdata_valid, err, exc_adel, exc_ades, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  logic        t_stall, t_rdata_valid, t_err, t_exc_adel, t_exc_ades, t_bus_req, t_bus_we;
  logic [31:0] t_rdata, t_bus_addr, t_bus_wdata;
  logic [3:0]  t_bus_be;

  int n_pass   = 0;
  int n_checks = 0;

  m_dmem_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .err(err), .exc_adel(exc_adel), .exc_ades(exc_ades),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  m_dmem_ctrl #(.TIMEOUT_CYC(3)) dut_t (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(t_stall), .rdata(t_rdata),
    .rdata_valid(t_rdata_valid), .err(t_err), .exc_adel(t_exc_adel), .exc_ades(t_exc_ades),
    .bus_req(t_bus_req), .bus_we(t_bus_we), .bus_addr(t_bus_addr), .bus_be(t_bus_be),
    .bus_wdata(t_bus_wdata), .bus_ack(t_bus_ack), .bus_rdata(bus_rdata)
  );

  // Observation mux: which DUT the transaction runner watches and acks.
  logic        sel_t = 1'b0;
  logic        o_stall, o_rdv, o_err, o_req, o_we;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0]  o_be;
  assign o_stall = sel_t ? t_stall       : stall;
  assign o_rdv   = sel_t ? t_rdata_valid : rdata_valid;
  assign o_err   = sel_t ? t_err         : err;
  assign o_req   = sel_t ? t_bus_req     : bus_req;
  assign o_we    = sel_t ? t_bus_we      : bus_we;
  assign o_rdata = sel_t ? t_rdata       : rdata;
  assign o_addr  = sel_t ? t_bus_addr    : bus_addr;
  assign o_wdata = sel_t ? t_bus_wdata   : bus_wdata;
  assign o_be    = sel_t ? t_bus_be      : bus_be;

  typedef struct {
    int          stall_cyc;
    int          req_cyc;
    int          cycles;
    int          rdv;
    int          err_cnt;
    bit          stable;
    bit          done_seen;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] rd_done;
    logic        err_done;
  } obs_t;

  // ---------------- reference model (byte-lane arithmetic) ----------------
  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    int lo = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << lo);
    if (sz == 2'd1) return (lo >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic bit model_misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  // Presents one M-stage request and records what the selected DUT does until stall
  // drops (DONE). waits < 0 means the bus never acks. A junk ack is thrown in while
  // the FSM should still be in IDLE. Bounded at 64 cycles.
  task automatic run_txn(input logic we, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input int waits, input logic [31:0] word,
                         output obs_t o);
    logic ackv;
    o.stall_cyc = 0; o.req_cyc = 0; o.cycles = 0; o.rdv = 0; o.err_cnt = 0;
    o.stable = 1'b1; o.done_seen = 1'b0; o.we = 1'b0; o.addr = '0; o.wd = '0;
    o.be = '0; o.rd_done = '0; o.err_done = 1'b0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
    for (int c = 0; c < 64; c++) begin
      ackv = (waits >= 0 && c == waits + 1) || (c == 0 && ($urandom % 2 == 1));
      if (sel_t) t_bus_ack = ackv; else bus_ack = ackv;
      bus_rdata = (waits >= 0 && c == waits + 1) ? word : $urandom;
      @(negedge clk);
      o.cycles = c + 1;
      if (o_stall) o.stall_cyc++;
      if (o_rdv)   o.rdv++;
      if (o_err)   o.err_cnt++;
      if (o_req) begin
        if (o.req_cyc == 0) begin
          o.we = o_we; o.addr = o_addr; o.wd = o_wdata; o.be = o_be;
        end else if (o.we !== o_we || o.addr !== o_addr || o.wd !== o_wdata || o.be !== o_be) begin
          o.stable = 1'b0;
        end
        o.req_cyc++;
      end
      if (c > 0 && !o_stall) begin
        o.done_seen = 1'b1; o.rd_done = o_rdata; o.err_done = o_err;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    bus_ack = 1'b0; t_bus_ack = 1'b0;
    if (!o.done_seen) $display("FAIL txn_timeout: stall never released within 64 cycles");
  endtask

  task automatic pulse_reset();
    req_valid = 1'b0; bus_ack = 1'b0; t_bus_ack = 1'b0;
    #2 reset = 1'b0;
    #3 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata} === '0) n_pass++;
    else $display("FAIL reset_bus: got req=%0b we=%0b be=%h addr=%h wd=%h, need all 0",
                  bus_req, bus_we, bus_be, bus_addr, bus_wdata);
    n_checks++;
    if (rdata === 32'h0 && {stall, rdata_valid, err, exc_adel, exc_ades} === 5'b0) n_pass++;
    else $display("FAIL reset_out: got rdata=%h stall=%0b rdv=%0b err=%0b, need 0",
                  rdata, stall, rdata_valid, err);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (bus_req === 1'b0 && stall === 1'b0) n_pass++;
    else $display("FAIL idle_no_req: got bus_req=%0b stall=%0b need 0/0", bus_req, stall);
    @(posedge clk); #1;
  endtask

  task automatic test_store_word();
    obs_t o;
    run_txn(1'b1, 2'b10, 32'h100, 32'h12345678, 0, 32'h0BADF00D, o);
    req_valid = 1'b0;
    n_checks++;
    if (o.stall_cyc == 2 && o.req_cyc == 1 && o.cycles == 3) n_pass++;
    else $display("FAIL sw_timing: got stall=%0d req=%0d cyc=%0d need 2/1/3", o.stall_cyc, o.req_cyc, o.cycles);
    n_checks++;
    if (o.addr === 32'h100 && o.be === 4'hF && o.wd === 32'h12345678 && o.we === 1'b1) n_pass++;
    else $display("FAIL sw_bus: got addr=%h be=%h wd=%h we=%0b need 100/f/12345678/1", o.addr, o.be, o.wd, o.we);
    n_checks++;
    if (o.rdv == 0 && o.err_cnt == 0) n_pass++;
    else $display("FAIL sw_pulses: got rdv=%0d err=%0d need 0/0", o.rdv, o.err_cnt);
    @(negedge clk);
    n_checks++;
    if (stall === 1'b0 && bus_req === 1'b0) n_pass++;
    else $display("FAIL sw_after: got stall=%0b bus_req=%0b need 0/0", stall, bus_req);
    @(posedge clk); #1;
  endtask

  task automatic test_sub_word();
    obs_t o;
    run_txn(1'b1, 2'b00, 32'h103, 32'h000000AB, 1, 32'h0, o);
    n_checks++;
    if (o.addr === 32'h100 && o.be === 4'b1000 && o.wd === 32'hABABABAB && o.stable) n_pass++;
    else $display("FAIL sb_bus: got addr=%h be=%b wd=%h stable=%0b need 100/1000/abababab/1", o.addr, o.be, o.wd, o.stable);
    // Back-to-back: the next store is presented right after DONE and must stall at once.
    run_txn(1'b1, 2'b01, 32'h102, 32'h0000BEEF, 0, 32'h0, o);
    req_valid = 1'b0;
    n_checks++;
    if (o.addr === 32'h100 && o.be === 4'b1100 && o.wd === 32'hBEEFBEEF) n_pass++;
    else $display("FAIL sh_bus: got addr=%h be=%b wd=%h need 100/1100/beefbeef", o.addr, o.be, o.wd);
    n_checks++;
    if (o.stall_cyc == 2 && o.req_cyc == 1) n_pass++;
    else $display("FAIL b2b_timing: got stall=%0d req=%0d need 2/1", o.stall_cyc, o.req_cyc);
  endtask

  task automatic test_load_wait();
    obs_t o;
    run_txn(1'b0, 2'b10, 32'h200, 32'h0, 4, 32'hCAFEF00D, o);
    req_valid = 1'b0;
    n_checks++;
    if (o.stall_cyc == 6 && o.req_cyc == 5 && o.cycles == 7 && o.stable) n_pass++;
    else $display("FAIL lw_timing: got stall=%0d req=%0d cyc=%0d stable=%0b need 6/5/7/1",
                  o.stall_cyc, o.req_cyc, o.cycles, o.stable);
    n_checks++;
    if (o.rd_done === 32'hCAFEF00D && o.rdv == 1 && o.we === 1'b0 && o.be === 4'hF) n_pass++;
    else $display("FAIL lw_data: got rdata=%h rdv=%0d we=%0b be=%h need cafef00d/1/0/f", o.rd_done, o.rdv, o.we, o.be);
    @(negedge clk);
    n_checks++;
    if (rdata_valid === 1'b0 && rdata === 32'hCAFEF00D) n_pass++;
    else $display("FAIL lw_hold: got rdv=%0b rdata=%h need 0/cafef00d", rdata_valid, rdata);
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    obs_t o;
    pulse_reset();
    sel_t = 1'b1;
    run_txn(1'b0, 2'b10, 32'h300, 32'h0, 2, 32'h5A5A1234, o);
    n_checks++;
    if (o.rd_done === 32'h5A5A1234 && o.err_cnt == 0) n_pass++;
    else $display("FAIL to_preload: got rdata=%h err=%0d need 5a5a1234/0", o.rd_done, o.err_cnt);
    run_txn(1'b1, 2'b10, 32'h304, 32'h11112222, -1, 32'h0, o);
    req_valid = 1'b0;
    n_checks++;
    if (o.req_cyc == 4 && o.stall_cyc == 5 && o.done_seen) n_pass++;
    else $display("FAIL to_timing: got req=%0d stall=%0d done=%0b need 4/5/1", o.req_cyc, o.stall_cyc, o.done_seen);
    n_checks++;
    if (o.err_done === 1'b1 && o.err_cnt == 1 && o.rd_done === 32'h0) n_pass++;
    else $display("FAIL to_err: got err=%0b cnt=%0d rdata=%h need 1/1/0", o.err_done, o.err_cnt, o.rd_done);
    @(negedge clk);
    n_checks++;
    if (t_err === 1'b0 && t_bus_req === 1'b0) n_pass++;
    else $display("FAIL to_after: got err=%0b bus_req=%0b need 0/0", t_err, t_bus_req);
    sel_t = 1'b0;
    pulse_reset();
  endtask

  task automatic test_misalign();
`ifdef MISALIGN_EXC_EN
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b01; req_addr = 32'h101; req_wdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (exc_adel === 1'b1 && exc_ades === 1'b0 && stall === 1'b0 && bus_req === 1'b0) n_pass++;
      else $display("FAIL lh_exc: got adel=%0b ades=%0b stall=%0b bus_req=%0b need 1/0/0/0",
                    exc_adel, exc_ades, stall, bus_req);
      @(posedge clk); #1;
    end
    req_we = 1'b1; req_size = 2'b10; req_addr = 32'h102;
    @(negedge clk);
    n_checks++;
    if (exc_ades === 1'b1 && exc_adel === 1'b0 && stall === 1'b0) n_pass++;
    else $display("FAIL sw_exc: got ades=%0b adel=%0b stall=%0b need 1/0/0", exc_ades, exc_adel, stall);
    @(posedge clk); #1;
    req_valid = 1'b0;
`else
    obs_t o;
    run_txn(1'b0, 2'b01, 32'h101, 32'h0, 1, 32'h00C0FFEE, o);
    req_valid = 1'b0;
    n_checks++;
    if (o.be === 4'b0011 && o.addr === 32'h100 && o.rd_done === 32'h00C0FFEE && o.stall_cyc == 3) n_pass++;
    else $display("FAIL lh_forced: got be=%b addr=%h rdata=%h stall=%0d need 0011/100/00c0ffee/3",
                  o.be, o.addr, o.rd_done, o.stall_cyc);
    n_checks++;
    if (exc_adel === 1'b0 && exc_ades === 1'b0) n_pass++;
    else $display("FAIL exc_tied: got adel=%0b ades=%0b need 0/0", exc_adel, exc_ades);
`endif
  endtask

  task automatic test_reset_mid_busy();
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h400; req_wdata = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (bus_req === 1'b1) n_pass++;
    else $display("FAIL rst_busy_pre: got bus_req=%0b need 1", bus_req);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (bus_req === 1'b0 && bus_be === 4'h0) n_pass++;
    else $display("FAIL rst_async: got bus_req=%0b be=%h need 0/0", bus_req, bus_be);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (rdata_valid === 1'b0 && bus_req === 1'b0 && rdata === 32'h0) n_pass++;
      else $display("FAIL late_ack: got rdv=%0b bus_req=%0b rdata=%h need 0/0/0", rdata_valid, bus_req, rdata);
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_random();
    obs_t o;
    logic we;
    logic [1:0] sz;
    logic [31:0] a, wd, word;
    int w;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom % 2); sz = 2'($urandom % 4); a = $urandom; wd = $urandom;
      word = $urandom; w = int'($urandom % 6);
`ifdef MISALIGN_EXC_EN
      if (model_misaligned(sz, a)) a[1:0] = 2'b00;
`endif
      run_txn(we, sz, a, wd, w, word, o);
      n_checks++;
      if (o.stall_cyc == w + 2 && o.req_cyc == w + 1 && o.cycles == w + 3 && o.stable) n_pass++;
      else $display("FAIL rnd_timing[%0d]: got stall=%0d req=%0d cyc=%0d stable=%0b need %0d/%0d/%0d/1",
                    i, o.stall_cyc, o.req_cyc, o.cycles, o.stable, w + 2, w + 1, w + 3);
      n_checks++;
      if (o.addr === (a & 32'hFFFFFFFC) && o.be === model_be(sz, a) && o.we === we &&
          o.wd === model_wdata(sz, wd)) n_pass++;
      else $display("FAIL rnd_bus[%0d]: got addr=%h be=%h we=%0b wd=%h need %h/%h/%0b/%h", i, o.addr,
                    o.be, o.we, o.wd, a & 32'hFFFFFFFC, model_be(sz, a), we, model_wdata(sz, wd));
      n_checks++;
      if (o.rd_done === word && o.rdv == (we ? 0 : 1) && o.err_cnt == 0) n_pass++;
      else $display("FAIL rnd_done[%0d]: got rdata=%h rdv=%0d err=%0d need %h/%0d/0",
                    i, o.rd_done, o.rdv, o.err_cnt, word, we ? 0 : 1);
      if ($urandom % 4 == 0) begin
        req_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_addr = 32'h0; req_wdata = 32'h0; bus_ack = 1'b0; t_bus_ack = 1'b0; bus_rdata = 32'h0;
    #12;
    test_reset();
    test_store_word();
    test_sub_word();
    test_load_wait();
    test_timeout();
    test_misalign();
    test_reset_mid_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
